// File: rtl/dmem_arbiter_if.sv
// Bundles the core, loader and RAM sides of the data-memory arbiter.
// slave = arbiter view, master = requester/RAM view.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_gnt;
   logic              core_rvalid;
   logic [DATA_W-1:0] core_rdata;
   logic              core_stall;

   logic              ld_req;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_lock;
   logic              ld_gnt;
   logic              ld_rvalid;
   logic [DATA_W-1:0] ld_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      output core_gnt, core_rvalid, core_rdata, core_stall,
      input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
      output ld_gnt, ld_rvalid, ld_rdata,
      output mem_addr, mem_wdata, mem_we,
      input  mem_rdata
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      input  core_gnt, core_rvalid, core_rdata, core_stall,
      output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
      input  ld_gnt, ld_rvalid, ld_rdata,
      input  mem_addr, mem_wdata, mem_we,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Core/loader arbiter for the data RAM: zero-cycle grant, read data one cycle later.
// Denied requesters hold their fields; core priority with a wait-count guard and a loader lock mode.
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   dmem_arbiter_if.slave      bus
);

   localparam logic [0:0] ST_ARB    = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;
   localparam logic [3:0] WAIT_SAT  = 4'(MAX_WAIT);

   logic [0:0] state_q;
   logic [0:0] state_d;
   logic [0:0] state_eff;
   logic [3:0] ld_wait_q;
   logic [3:0] ld_wait_d;
   logic       core_own_q;
   logic       ld_own_q;

   logic       core_gnt;
   logic       ld_gnt;
   logic       locked_hold;
   logic       ld_force;

   // While reset is asserted the grant logic behaves as in ARB, whatever the register holds.
   always_comb begin
      state_eff   = rst_n ? state_q : ST_ARB;
      locked_hold = (state_eff == ST_LOCKED) && bus.ld_lock;
      ld_force    = bus.ld_req && (ld_wait_q == WAIT_SAT);
      core_gnt    = 1'b0;
      ld_gnt      = 1'b0;
      if (locked_hold) begin
         ld_gnt = bus.ld_req;
      end else if (ld_force) begin
         ld_gnt = 1'b1;
      end else if (bus.core_req) begin
         core_gnt = 1'b1;
      end else if (bus.ld_req) begin
         ld_gnt = 1'b1;
      end
   end

   always_comb begin
      if (locked_hold || (ld_gnt && bus.ld_lock)) begin
         state_d = ST_LOCKED;
      end else begin
         state_d = ST_ARB;
      end
   end

   always_comb begin
      ld_wait_d = 4'd0;
      if (bus.ld_req && !ld_gnt) begin
         ld_wait_d = (ld_wait_q >= WAIT_SAT) ? WAIT_SAT : ld_wait_q + 4'd1;
      end
   end

   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_we    = 1'b0;
      if (core_gnt) begin
         bus.mem_addr  = bus.core_addr;
         bus.mem_wdata = bus.core_wdata;
         bus.mem_we    = bus.core_we;
      end else if (ld_gnt) begin
         bus.mem_addr  = bus.ld_addr;
         bus.mem_wdata = bus.ld_wdata;
         bus.mem_we    = bus.ld_we;
      end
   end

   // Owner tags: a read accepted now returns data on the next cycle to its requester only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_ARB;
         ld_wait_q  <= 4'd0;
         core_own_q <= 1'b0;
         ld_own_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_wait_q  <= ld_wait_d;
         core_own_q <= core_gnt && !bus.core_we;
         ld_own_q   <= ld_gnt && !bus.ld_we;
      end
   end

   assign bus.core_gnt    = core_gnt;
   assign bus.ld_gnt      = ld_gnt;
   assign bus.core_stall  = bus.core_req && !core_gnt;
   assign bus.core_rvalid = core_own_q;
   assign bus.ld_rvalid   = ld_own_q;
   assign bus.core_rdata  = core_own_q ? bus.mem_rdata : '0;
   assign bus.ld_rdata    = ld_own_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency RAM model.
module tb_dmem_arbiter;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   logic [31:0] ram [0:255];

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr[9:2]];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
      bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0; bus.ld_lock = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      repeat (2) cyc();
      rst_n = 1'b1;
      #2;
      n_checks++; if (bus.core_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_core_gnt: got %0b want 0", bus.core_gnt); end
      n_checks++; if (bus.ld_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_ld_gnt: got %0b want 0", bus.ld_gnt); end
      n_checks++; if (bus.core_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_core_rvalid: got %0b want 0", bus.core_rvalid); end
      n_checks++; if (bus.ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_ld_rvalid: got %0b want 0", bus.ld_rvalid); end
      n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %0b want 0", bus.mem_we); end
      n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h want 0", bus.mem_addr); end
      n_checks++; if (bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL reset_core_stall: got %0b want 0", bus.core_stall); end
   endtask

   task automatic test_core_rw();
      cyc();
      bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'h10; bus.core_wdata = 32'hDEADBEEF;
      #2;
      n_checks++; if (bus.core_gnt !== 1'b1) begin n_fail++; $display("FAIL rw_wr_gnt: got %0b want 1", bus.core_gnt); end
      n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rw_wr_mem_we: got %0b want 1", bus.mem_we); end
      n_checks++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL rw_wr_mem_addr: got %0h want 10", bus.mem_addr); end
      n_checks++; if (bus.mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rw_wr_mem_wdata: got %0h want deadbeef", bus.mem_wdata); end
      cyc();
      bus.core_we = 1'b0; bus.core_wdata = '0;
      #2;
      n_checks++; if (bus.core_gnt !== 1'b1) begin n_fail++; $display("FAIL rw_rd_gnt: got %0b want 1", bus.core_gnt); end
      n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rw_rd_mem_we: got %0b want 0", bus.mem_we); end
      n_checks++; if (bus.core_rvalid !== 1'b0) begin n_fail++; $display("FAIL rw_wr_no_rvalid: got %0b want 0", bus.core_rvalid); end
      cyc();
      bus.core_req = 1'b0;
      #2;
      n_checks++; if (bus.core_rvalid !== 1'b1) begin n_fail++; $display("FAIL rw_rvalid: got %0b want 1", bus.core_rvalid); end
      n_checks++; if (bus.core_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rw_rdata: got %0h want deadbeef", bus.core_rdata); end
      n_checks++; if (bus.ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL rw_ld_rvalid: got %0b want 0", bus.ld_rvalid); end
      n_checks++; if (bus.ld_rdata !== 32'h0) begin n_fail++; $display("FAIL rw_ld_rdata: got %0h want 0", bus.ld_rdata); end
      cyc();
      #2;
      n_checks++; if (bus.core_rvalid !== 1'b0) begin n_fail++; $display("FAIL rw_rvalid_drop: got %0b want 0", bus.core_rvalid); end
   endtask

   // Loader reads 0x10 (DEADBEEF) against a continuous core: grants land at cycles 4 and 9.
   task automatic test_contention();
      logic exp_ld;
      logic prev_ld;
      prev_ld = 1'b0;
      for (int c = 0; c < 11; c++) begin
         cyc();
         if (c == 0) begin
            bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h14;
            bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h10;
         end
         #2;
         exp_ld = ((c % 5) == 4);
         n_checks++; if (bus.ld_gnt !== exp_ld) begin n_fail++; $display("FAIL cont_ld_gnt c%0d: got %0b want %0b", c, bus.ld_gnt, exp_ld); end
         n_checks++; if (bus.core_gnt !== !exp_ld) begin n_fail++; $display("FAIL cont_core_gnt c%0d: got %0b want %0b", c, bus.core_gnt, !exp_ld); end
         n_checks++; if (bus.core_stall !== exp_ld) begin n_fail++; $display("FAIL cont_stall c%0d: got %0b want %0b", c, bus.core_stall, exp_ld); end
         n_checks++; if (bus.mem_addr !== (exp_ld ? 32'h10 : 32'h14)) begin n_fail++; $display("FAIL cont_mem_addr c%0d: got %0h", c, bus.mem_addr); end
         n_checks++; if (bus.ld_rvalid !== prev_ld) begin n_fail++; $display("FAIL cont_ld_rvalid c%0d: got %0b want %0b", c, bus.ld_rvalid, prev_ld); end
         if (prev_ld) begin
            n_checks++; if (bus.ld_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cont_ld_rdata c%0d: got %0h want deadbeef", c, bus.ld_rdata); end
            n_checks++; if (bus.core_rvalid !== 1'b0) begin n_fail++; $display("FAIL cont_core_rvalid c%0d: got %0b want 0", c, bus.core_rvalid); end
         end
         prev_ld = exp_ld;
      end
      cyc();
      idle();
   endtask

   task automatic test_lock_burst();
      // Entry: the locked word waits out four core grants before it is forced in.
      for (int c = 0; c < 5; c++) begin
         cyc();
         if (c == 0) begin
            bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h14;
            bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_lock = 1'b1; bus.ld_addr = 32'h40; bus.ld_wdata = 32'hA0;
         end
         #2;
         n_checks++; if (bus.ld_gnt !== (c == 4)) begin n_fail++; $display("FAIL lock_entry_ld_gnt c%0d: got %0b", c, bus.ld_gnt); end
      end
      for (int w = 1; w < 7; w++) begin
         if (w == 4) begin
            cyc();
            bus.ld_req = 1'b0;
            #2;
            n_checks++; if (bus.core_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_bubble_core_gnt: got %0b want 0", bus.core_gnt); end
            n_checks++; if (bus.core_stall !== 1'b1) begin n_fail++; $display("FAIL lock_bubble_stall: got %0b want 1", bus.core_stall); end
            n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL lock_bubble_mem_we: got %0b want 0", bus.mem_we); end
         end
         cyc();
         bus.ld_req = 1'b1; bus.ld_addr = 32'h40 + 32'(4 * w); bus.ld_wdata = 32'hA0 + 32'(w);
         #2;
         n_checks++; if (bus.ld_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_w%0d_ld_gnt: got %0b want 1", w, bus.ld_gnt); end
         n_checks++; if (bus.core_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_w%0d_core_gnt: got %0b want 0", w, bus.core_gnt); end
         n_checks++; if (bus.core_stall !== 1'b1) begin n_fail++; $display("FAIL lock_w%0d_stall: got %0b want 1", w, bus.core_stall); end
         n_checks++; if (bus.mem_addr !== 32'h40 + 32'(4 * w)) begin n_fail++; $display("FAIL lock_w%0d_mem_addr: got %0h", w, bus.mem_addr); end
      end
      cyc();
      bus.ld_lock = 1'b0; bus.ld_addr = 32'h5C; bus.ld_wdata = 32'hA7;
      #2;
      n_checks++; if (bus.core_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_release_core_gnt: got %0b want 1", bus.core_gnt); end
      n_checks++; if (bus.ld_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_release_ld_gnt: got %0b want 0", bus.ld_gnt); end
      n_checks++; if (bus.mem_addr !== 32'h14) begin n_fail++; $display("FAIL lock_release_mem_addr: got %0h want 14", bus.mem_addr); end
      cyc();
      bus.core_req = 1'b0;
      #2;
      n_checks++; if (bus.ld_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_last_ld_gnt: got %0b want 1", bus.ld_gnt); end
      n_checks++; if (bus.mem_addr !== 32'h5C) begin n_fail++; $display("FAIL lock_last_mem_addr: got %0h want 5c", bus.mem_addr); end
      // Lock without a request must not take ownership.
      for (int c = 0; c < 2; c++) begin
         cyc();
         bus.ld_req = 1'b0; bus.ld_lock = 1'b1; bus.core_req = 1'b1;
         #2;
         n_checks++; if (bus.core_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_noreq_core_gnt c%0d: got %0b want 1", c, bus.core_gnt); end
      end
      cyc();
      idle();
   endtask

   task automatic test_read_routing();
      cyc();
      bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h20; bus.ld_wdata = 32'h1234;
      #2;
      n_checks++; if (bus.ld_gnt !== 1'b1) begin n_fail++; $display("FAIL route_wr0_ld_gnt: got %0b want 1", bus.ld_gnt); end
      cyc();
      bus.ld_addr = 32'h24; bus.ld_wdata = 32'h5678;
      #2;
      n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL route_wr1_mem_we: got %0b want 1", bus.mem_we); end
      cyc();
      bus.ld_we = 1'b0; bus.ld_addr = 32'h20; bus.ld_wdata = '0;
      #2;
      n_checks++; if (bus.ld_gnt !== 1'b1) begin n_fail++; $display("FAIL route_rd_ld_gnt: got %0b want 1", bus.ld_gnt); end
      n_checks++; if (bus.ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL route_wr_no_rvalid: got %0b want 0", bus.ld_rvalid); end
      cyc();
      bus.ld_req = 1'b0; bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h24;
      #2;
      n_checks++; if (bus.core_gnt !== 1'b1) begin n_fail++; $display("FAIL route_core_gnt: got %0b want 1", bus.core_gnt); end
      n_checks++; if (bus.ld_rvalid !== 1'b1) begin n_fail++; $display("FAIL route_ld_rvalid: got %0b want 1", bus.ld_rvalid); end
      n_checks++; if (bus.ld_rdata !== 32'h1234) begin n_fail++; $display("FAIL route_ld_rdata: got %0h want 1234", bus.ld_rdata); end
      n_checks++; if (bus.core_rvalid !== 1'b0) begin n_fail++; $display("FAIL route_core_rvalid0: got %0b want 0", bus.core_rvalid); end
      n_checks++; if (bus.core_rdata !== 32'h0) begin n_fail++; $display("FAIL route_core_rdata0: got %0h want 0", bus.core_rdata); end
      cyc();
      bus.core_req = 1'b0;
      #2;
      n_checks++; if (bus.core_rvalid !== 1'b1) begin n_fail++; $display("FAIL route_core_rvalid: got %0b want 1", bus.core_rvalid); end
      n_checks++; if (bus.core_rdata !== 32'h5678) begin n_fail++; $display("FAIL route_core_rdata: got %0h want 5678", bus.core_rdata); end
      n_checks++; if (bus.ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL route_ld_rvalid1: got %0b want 0", bus.ld_rvalid); end
      n_checks++; if (bus.ld_rdata !== 32'h0) begin n_fail++; $display("FAIL route_ld_rdata1: got %0h want 0", bus.ld_rdata); end
      cyc();
      idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [0:2];
      logic [31:0] datas [0:2];
      addrs[0] = 32'h20; addrs[1] = 32'h24; addrs[2] = 32'h4C;
      datas[0] = 32'h1234; datas[1] = 32'h5678; datas[2] = 32'hA3;
      for (int k = 0; k < 4; k++) begin
         cyc();
         bus.core_req = (k < 3); bus.core_we = 1'b0; bus.core_addr = (k < 3) ? addrs[k] : 32'h0;
         #2;
         if (k < 3) begin
            n_checks++; if (bus.core_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt k%0d: got %0b want 1", k, bus.core_gnt); end
         end
         n_checks++; if (bus.core_rvalid !== (k > 0)) begin n_fail++; $display("FAIL b2b_rvalid k%0d: got %0b want %0b", k, bus.core_rvalid, (k > 0)); end
         if (k > 0) begin
            n_checks++; if (bus.core_rdata !== datas[k-1]) begin n_fail++; $display("FAIL b2b_rdata k%0d: got %0h want %0h", k, bus.core_rdata, datas[k-1]); end
         end
      end
      cyc();
      idle();
   endtask

   task automatic test_reset_mid();
      cyc();
      bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_lock = 1'b1; bus.ld_addr = 32'h60; bus.ld_wdata = 32'h0;
      #2;
      n_checks++; if (bus.ld_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_lock_gnt: got %0b want 1", bus.ld_gnt); end
      cyc();
      bus.ld_req = 1'b0; bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h20;
      #2;
      n_checks++; if (bus.core_gnt !== 1'b0) begin n_fail++; $display("FAIL rmid_locked_core_gnt: got %0b want 0", bus.core_gnt); end
      n_checks++; if (bus.core_stall !== 1'b1) begin n_fail++; $display("FAIL rmid_locked_stall: got %0b want 1", bus.core_stall); end
      cyc();
      rst_n = 1'b0;
      #2;
      n_checks++; if (bus.core_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_rst_core_gnt: got %0b want 1", bus.core_gnt); end
      cyc();
      rst_n = 1'b1; bus.core_req = 1'b0;
      #2;
      n_checks++; if (bus.core_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_core_rvalid: got %0b want 0", bus.core_rvalid); end
      n_checks++; if (bus.ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_ld_rvalid: got %0b want 0", bus.ld_rvalid); end
      cyc();
      bus.core_req = 1'b1;
      #2;
      n_checks++; if (bus.core_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_post_core_gnt: got %0b want 1", bus.core_gnt); end
      cyc();
      idle();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_core_rw();
      test_contention();
      test_lock_burst();
      test_read_routing();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data memory between the smips core load/store port and an external loader/debug port. The core normally has priority. A saturating wait counter guarantees that the loader gets service, and a lock mode gives the loader exclusive bursts for program/data download. The arbiter sits between the core's ALU-result/store-data path and `data_memory`. It drives a stall that freezes the program sequencer while the core is denied.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 4, loader wait cycles before forced grant (1..15)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `core_req`  in  1  core access request
- `core_we`  in  1  1 = write, 0 = read
- `core_addr`  in  `ADDR_W`  core address
- `core_wdata`  in  `DATA_W`  core store data
- `core_gnt`  out  1  core access accepted this cycle
- `core_rvalid`  out  1  core read data valid
- `core_rdata`  out  `DATA_W`  core read data
- `core_stall`  out  1  `core_req && !core_gnt`
- `ld_req`, `ld_we`, `ld_addr`, `ld_wdata`  in  1/1/`ADDR_W`/`DATA_W`  loader request fields
- `ld_lock`  in  1  request exclusive ownership
- `ld_gnt`, `ld_rvalid`  out  1  loader grant / read valid
- `ld_rdata`  out  `DATA_W`  loader read data
- `mem_addr`  out  `ADDR_W`  to RAM
- `mem_wdata`  out  `DATA_W`  to RAM
- `mem_we`  out  1  RAM write strobe
- `mem_rdata`  in  `DATA_W`  RAM read data, valid one cycle after address

## Operation
- Request handshake:
  - A requester holds `req` and all of its fields stable until it sees `gnt`.
  - The cycle in which `gnt` is high is the accept cycle.
  - At most one `gnt` is high per cycle.
- `gnt` is combinational from the `req` inputs, the FSM state and `ld_wait`.
- In the accept cycle, the winner's addr/wdata/we drive the `mem_*` outputs.
- With no grant: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Read return:
  - A registered owner tag records which requester had a read accepted.
  - The next cycle, that owner's `rvalid` = 1 and its `rdata` = `mem_rdata`.
  - The non-owner's `rdata` = 0.
  - Writes produce no `rvalid`.
- `ld_wait` is a 4-bit counter:
  - Increments (saturating at `MAX_WAIT`) when `ld_req && !ld_gnt`.
  - Clears to 0 on `ld_gnt` or `!ld_req`.
- FSM states are ARB and LOCKED.
- ARB:
  - If `ld_req` and `ld_wait == MAX_WAIT`, the loader wins.
  - Otherwise, if `core_req`, the core wins.
  - Otherwise, if `ld_req`, the loader wins.
  - If `ld_gnt && ld_lock`, next state = LOCKED.
- LOCKED:
  - If `ld_lock` = 1: `core_gnt` = 0 always; `ld_gnt` = `ld_req`; state stays LOCKED.
  - If `ld_lock` = 0: ARB rules apply this same cycle and next state = ARB.
- Simultaneous requests with `ld_wait < MAX_WAIT` go to the core. The denied loader's `ld_wait` increments.

## Timing
- Reset values (at the edge with `rst_n` = 0):
  - state = ARB, `ld_wait` = 0, owner tag cleared.
  - `core_rvalid` = `ld_rvalid` = 0 in the following cycle, even if a read was accepted in the reset cycle. The pending return is dropped.
  - Combinational outputs follow the inputs under state ARB.
- Latency:
  - Grant is zero-cycle: same cycle as `req`, when the requester wins.
  - Read data arrives 1 cycle after grant.
  - A write commits at the accept-cycle edge.
- Back-to-back:
  - One accept per cycle; a new request may be granted in the cycle its predecessor's `rvalid` is high.
  - A core requesting continuously while the loader waits yields exactly one loader grant every `MAX_WAIT`+1 cycles.
- `core_stall` is combinational. It is high in every cycle the core is denied, including every LOCKED cycle with `core_req` high.
- `ld_lock` asserted without `ld_req` in ARB has no effect. Entry into LOCKED requires a granted loader access.

## Test plan
- Reset and idle: hold `rst_n` = 0 for 2 cycles, then no requests -> all `gnt`/`rvalid`/`mem_we` = 0, `mem_addr` = 0, `core_stall` = 0.
- Core read/write: core writes 0xDEADBEEF to 0x10, then reads 0x10 -> `core_gnt` in both request cycles, `mem_we` = 1 in the first only; `core_rvalid` = 1 with `core_rdata` = 0xDEADBEEF one cycle after the read grant; `ld_rvalid` = 0.
- Contention/starvation guard: `core_req` and `ld_req` both held with `MAX_WAIT` = 4 -> core granted cycles 0–3, loader granted cycle 4 with `core_stall` = 1 there, core regranted at cycle 5, `ld_wait` back to 0.
- Lock burst:
  - Stimulus: loader writes 8 words with `ld_lock` = 1 while `core_req` is held, then drops `ld_lock` on the final word.
  - Required response: `core_gnt` = 0 and `core_stall` = 1 throughout the burst.
  - Required response: on the final word with `ld_lock` = 0, ARB rules apply and the core wins. The loader keeps `ld_req` held and is granted the next cycle.
- Read return routing: loader reads 0x20 (preloaded 0x1234), core reads 0x24 (0x5678) in the next cycle -> `ld_rvalid` with 0x1234, then `core_rvalid` with 0x5678; never both `rvalid` high in one cycle.
- Reset mid-operation: core read granted in the cycle `rst_n` = 0 -> next cycle `core_rvalid` = 0; state ARB even if LOCKED before reset.
